mul8_err_sweeper: RTL

- Exhaustive characterisation harness for one approximate 8x8 multiplier from the library.
- Acts as the multiplier's neighbouring stage on both sides: sequences every operand pair into the multiplier under test (upstream) and consumes its product (downstream).
- Compares each product against the exact product and accumulates the library's error metrics: sum of absolute error, sum of squared error, worst-case error with its operands, and erroneous-output count.
- Used on FPGA/emulation to re-measure MAE/MSE/WCE/EP of a netlist on silicon.

---
 rtl/mul8_err_sweeper_pkg.sv | 26 ++
 rtl/mul8_err_sweeper_if.sv | 11 +
 rtl/mul8_err_sweeper_accum.sv | 89 ++++++++
 rtl/mul8_err_sweeper.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mul8_err_sweeper_pkg.sv
// Shared types and width helpers for the multiplier error-characterisation harness.
package mul_char_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  // Accumulators are sized so a full sweep with worst-case error cannot overflow.
  function automatic int sae_width(input int w);
    return 4 * w;
  endfunction

  function automatic int sse_width(input int w);
    return 6 * w;
  endfunction

  function automatic int err_cnt_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/mul8_err_sweeper_if.sv
// Operand/product bus between the sweeper and the multiplier under test.
interface mul8_err_sweeper_if #(
  parameter int W = 8
);
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_o;

  modport master (output mul_a, output mul_b, input mul_o);
  modport slave  (input mul_a, input mul_b, output mul_o);
endinterface

// File: rtl/mul8_err_sweeper_accum.sv
// Second pipeline stage: absolute error, its square, and the four running error metrics.
module mul_err_accum
  import mul_char_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int SAE_W = sae_width(W),
  parameter int SSE_W = sse_width(W),
  parameter int ERR_W = err_cnt_width(W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [2*W-1:0]   approx_i,
  input  logic [2*W-1:0]   exact_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [SAE_W-1:0] sae_o,
  output logic [SSE_W-1:0] sse_o,
  output logic [2*W-1:0]   wce_o,
  output logic [W-1:0]     wc_a_o,
  output logic [W-1:0]     wc_b_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic [2*W-1:0]   err_abs;
  logic [4*W-1:0]   err_sq;
  logic [SAE_W-1:0] sae_q, sae_d;
  logic [SSE_W-1:0] sse_q, sse_d;
  logic [2*W-1:0]   wce_q, wce_d;
  logic [W-1:0]     wc_a_q, wc_a_d, wc_b_q, wc_b_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  assign err_abs = (approx_i >= exact_i) ? (approx_i - exact_i) : (exact_i - approx_i);
  assign err_sq  = {{(2*W){1'b0}}, err_abs} * {{(2*W){1'b0}}, err_abs};

  always_comb begin
    sae_d     = sae_q;
    sse_d     = sse_q;
    wce_d     = wce_q;
    wc_a_d    = wc_a_q;
    wc_b_d    = wc_b_q;
    err_cnt_d = err_cnt_q;
    if (clr_i) begin
      sae_d     = '0;
      sse_d     = '0;
      wce_d     = '0;
      wc_a_d    = '0;
      wc_b_d    = '0;
      err_cnt_d = '0;
    end else if (valid_i) begin
      sae_d     = sae_q + SAE_W'(err_abs);
      sse_d     = sse_q + SSE_W'(err_sq);
      err_cnt_d = err_cnt_q + ERR_W'(err_abs != '0);
      // Strict compare keeps the first pair in sweep order on ties.
      if (err_abs > wce_q) begin
        wce_d  = err_abs;
        wc_a_d = a_i;
        wc_b_d = b_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sae_q     <= '0;
      sse_q     <= '0;
      wce_q     <= '0;
      wc_a_q    <= '0;
      wc_b_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      sae_q     <= sae_d;
      sse_q     <= sse_d;
      wce_q     <= wce_d;
      wc_a_q    <= wc_a_d;
      wc_b_q    <= wc_b_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign sae_o     = sae_q;
  assign sse_o     = sse_q;
  assign wce_o     = wce_q;
  assign wc_a_o    = wc_a_q;
  assign wc_b_o    = wc_b_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/mul8_err_sweeper.sv
// Exhaustive sweep harness: drives every operand pair into the multiplier under test
// and accumulates MAE/MSE/WCE/EP metrics against the exact product.
module mul8_err_sweeper
  import mul_char_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int SAE_W = sae_width(W),
  parameter int SSE_W = sse_width(W)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  mul8_err_sweeper_if.master          mul_if,
  output logic [SAE_W-1:0]            sae_o,
  output logic [SSE_W-1:0]            sse_o,
  output logic [2*W-1:0]              wce_o,
  output logic [W-1:0]                wc_a_o,
  output logic [W-1:0]                wc_b_o,
  output logic [err_cnt_width(W)-1:0] err_cnt_o
);

  sweep_state_t   state_q, state_d;
  logic           start_acc;
  logic [2*W-1:0] idx_q, idx_d;
  logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2*W-1:0] exact_c;

  logic           s1_valid_q, s1_valid_d;
  logic [2*W-1:0] s1_approx_q, s1_approx_d;
  logic [2*W-1:0] s1_exact_q, s1_exact_d;
  logic [W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  assign exact_c = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, op_b_q};

  // Abort outranks every transition, including a simultaneous start.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_d   = ST_SWEEP;
            start_acc = 1'b1;
          end
        end
        ST_SWEEP: if (idx_q == '1) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d       = idx_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    s1_valid_d  = 1'b0;
    s1_approx_d = s1_approx_q;
    s1_exact_d  = s1_exact_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    if (abort_i) begin
      s1_valid_d = 1'b0;
    end else if (start_acc) begin
      idx_d  = '0;
      op_a_d = '0;
      op_b_d = '0;
    end else if (state_q == ST_SWEEP) begin
      s1_valid_d  = 1'b1;
      s1_approx_d = mul_if.mul_o;
      s1_exact_d  = exact_c;
      s1_a_d      = op_a_q;
      s1_b_d      = op_b_q;
      idx_d       = idx_q + (2*W)'(1);
      // Operands stop on the last pair so they hold through DRAIN/DONE.
      if (idx_q != '1) {op_b_d, op_a_d} = idx_q + (2*W)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_approx_q <= '0;
      s1_exact_q  <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      s1_valid_q  <= s1_valid_d;
      s1_approx_q <= s1_approx_d;
      s1_exact_q  <= s1_exact_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
    end
  end

  mul_err_accum #(
    .W     (W),
    .SAE_W (SAE_W),
    .SSE_W (SSE_W),
    .ERR_W (err_cnt_width(W))
  ) u_accum (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (start_acc),
    .valid_i   (s1_valid_q & ~abort_i),
    .approx_i  (s1_approx_q),
    .exact_i   (s1_exact_q),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .sae_o     (sae_o),
    .sse_o     (sse_o),
    .wce_o     (wce_o),
    .wc_a_o    (wc_a_o),
    .wc_b_o    (wc_b_o),
    .err_cnt_o (err_cnt_o)
  );

  assign mul_if.mul_a = op_a_q;
  assign mul_if.mul_b = op_b_q;
  assign busy_o       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);

endmodule
